prewish5k_controller: RTL and testbench

Top-level controller for the iCE40 prewish blinky board. It generates its own power-on reset and debounces the active-low push button. On each accepted press it captures an 8-bit pattern from the active-low DIP switches and drives `the_led` through that pattern in a repeating 8-step cycle. It contains every other module of the design; the board wrapper connects it straight to the package pins.

---
 rtl/prewish5k_pkg.sv | 8 +
 rtl/SB_GB.sv | 7 +
 rtl/SB_IO.sv | 13 +
 rtl/prewish5k_blinky.sv | 42 ++++
 rtl/prewish5k_debounce.sv | 47 ++++
 rtl/prewish5k_controller.sv | 86 ++++++++
 tb/tb_prewish5k_controller.sv | 225 ++++++++++++++++++++++
 7 files changed

// File: rtl/prewish5k_pkg.sv
// Shared constants for the prewish5k blinky controller.
package prewish5k_pkg;
    localparam logic [4:0] POR_CYCLES      = 5'd16;
    localparam logic [4:0] DEBOUNCE_CYCLES = 5'd16;
    localparam int         LOCKOUT_SHIFT   = 3;
    localparam int         MASK_W          = 8;
    localparam int         IDX_W           = $clog2(MASK_W);
endpackage

// File: rtl/SB_GB.sv
// Passthrough simulation model of the iCE40 SB_GB global buffer.
module SB_GB (
    input  logic USER_SIGNAL_TO_GLOBAL_BUFFER,
    output logic GLOBAL_BUFFER_OUTPUT
);
    assign GLOBAL_BUFFER_OUTPUT = USER_SIGNAL_TO_GLOBAL_BUFFER;
endmodule

// File: rtl/SB_IO.sv
// Passthrough simulation model of the iCE40 SB_IO cell (input path only).
module SB_IO #(
    parameter logic [5:0] PIN_TYPE = 6'b000000,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic PACKAGE_PIN,
    output logic D_IN_0
);
    logic unused_cfg;

    assign unused_cfg = ^{PIN_TYPE, PULLUP};
    assign D_IN_0     = PACKAGE_PIN;
endmodule

// File: rtl/prewish5k_blinky.sv
// Mask register and 8-step pattern sequencer driving the registered LED.
module prewish5k_blinky
    import prewish5k_pkg::*;
#(
    parameter int BLINKY_MASK_CLK_BITS = 19
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              load,
    input  logic [MASK_W-1:0] data,
    output logic              run,
    output logic              the_led
);
    logic [MASK_W-1:0]               mask;
    logic [IDX_W-1:0]                step_idx;
    logic [BLINKY_MASK_CLK_BITS-1:0] step_cnt;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            mask     <= '0;
            run      <= 1'b0;
            step_idx <= '1;
            step_cnt <= '0;
        end else if (load) begin
            mask     <= data;
            run      <= 1'b1;
            step_idx <= '1;
            step_cnt <= '0;
        end else if (run) begin
            step_cnt <= step_cnt + BLINKY_MASK_CLK_BITS'(1);
            if (step_cnt == '1)
                step_idx <= step_idx - IDX_W'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst)
            the_led <= 1'b0;
        else
            the_led <= run & mask[step_idx];
    end
endmodule

// File: rtl/prewish5k_debounce.sv
// Button synchronizer, stable-count debouncer and post-accept re-arm lockout.
module prewish5k_debounce
    import prewish5k_pkg::*;
#(
    parameter int LOCKOUT_W = 23
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic accept,
    output logic lockout_active
);
    logic                 sync1_n;
    logic                 sync2_n;
    logic [4:0]           stable_cnt;
    logic                 pressed_q;
    logic [LOCKOUT_W-1:0] lockout_cnt;

    assign pressed        = (stable_cnt == DEBOUNCE_CYCLES);
    assign lockout_active = (lockout_cnt != '0);
    // Only the first cycle at full count can accept, so a press that lands in
    // lockout is dropped rather than held pending.
    assign accept         = pressed & ~pressed_q & ~lockout_active;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1_n     <= 1'b1;
            sync2_n     <= 1'b1;
            stable_cnt  <= '0;
            pressed_q   <= 1'b0;
            lockout_cnt <= '0;
        end else begin
            sync1_n   <= btn_n;
            sync2_n   <= sync1_n;
            pressed_q <= pressed;
            if (sync2_n)
                stable_cnt <= '0;
            else if (stable_cnt != DEBOUNCE_CYCLES)
                stable_cnt <= stable_cnt + 5'd1;
            if (accept)
                lockout_cnt <= '1;
            else if (lockout_active)
                lockout_cnt <= lockout_cnt - LOCKOUT_W'(1);
        end
    end
endmodule

// File: rtl/prewish5k_controller.sv
// Board-level controller: power-on reset, button input cell, debouncer and
// pattern sequencer.
module prewish5k_controller
    import prewish5k_pkg::*;
#(
    parameter int NEWMASK_CLK_BITS     = 26,
    parameter int BLINKY_MASK_CLK_BITS = 19
) (
    input  logic i_clk,
    output logic RST_O,
    input  logic the_button,
    input  logic i_bit7,
    input  logic i_bit6,
    input  logic i_bit5,
    input  logic i_bit4,
    input  logic i_bit3,
    input  logic i_bit2,
    input  logic i_bit1,
    input  logic i_bit0,
    output logic the_led,
    output logic o_led0,
    output logic o_led1,
    output logic o_led2,
    output logic o_led3
);
    // Relies on the FPGA configuration-time init; this counter has no reset.
    logic [4:0]        por_cnt = 5'd0;
    logic              por_rst;
    logic              rst;
    logic              btn_pin;
    logic              accept;
    logic              run;
    logic              pressed;
    logic              lockout_active;
    logic [MASK_W-1:0] dip_mask;

    always_ff @(posedge i_clk) begin
        if (por_cnt < POR_CYCLES)
            por_cnt <= por_cnt + 5'd1;
    end

    assign por_rst = (por_cnt < POR_CYCLES);

    SB_GB u_rst_gb (
        .USER_SIGNAL_TO_GLOBAL_BUFFER(por_rst),
        .GLOBAL_BUFFER_OUTPUT        (rst)
    );

    SB_IO #(
        .PIN_TYPE(6'b000001),
        .PULLUP  (1'b1)
    ) u_btn_io (
        .PACKAGE_PIN(the_button),
        .D_IN_0     (btn_pin)
    );

    assign dip_mask = ~{i_bit7, i_bit6, i_bit5, i_bit4, i_bit3, i_bit2, i_bit1, i_bit0};

    prewish5k_debounce #(
        .LOCKOUT_W(NEWMASK_CLK_BITS - LOCKOUT_SHIFT)
    ) u_debounce (
        .clk_sys       (i_clk),
        .rst           (rst),
        .btn_n         (btn_pin),
        .pressed       (pressed),
        .accept        (accept),
        .lockout_active(lockout_active)
    );

    prewish5k_blinky #(
        .BLINKY_MASK_CLK_BITS(BLINKY_MASK_CLK_BITS)
    ) u_blinky (
        .clk_sys(i_clk),
        .rst    (rst),
        .load   (accept),
        .data   (dip_mask),
        .run    (run),
        .the_led(the_led)
    );

    assign RST_O  = rst;
    assign o_led0 = run;
    assign o_led1 = pressed;
    assign o_led2 = lockout_active;
    assign o_led3 = rst;
endmodule

// File: tb/tb_prewish5k_controller.sv
// Scoreboard bench: LED transitions and accept pulses are queued by stimulus
// and consumed by independent monitors.
module tb_prewish5k_controller;
    localparam int STEP = 512;
    localparam int LAT  = 18;

    logic       clk = 1'b0;
    logic       rst_o;
    logic       the_button = 1'b1;
    logic [7:0] dip = 8'hFF;
    logic       the_led, o_led0, o_led1, o_led2, o_led3;

    prewish5k_controller #(
        .NEWMASK_CLK_BITS    (16),
        .BLINKY_MASK_CLK_BITS(9)
    ) dut (
        .i_clk     (clk),
        .RST_O     (rst_o),
        .the_button(the_button),
        .i_bit7    (dip[7]),
        .i_bit6    (dip[6]),
        .i_bit5    (dip[5]),
        .i_bit4    (dip[4]),
        .i_bit3    (dip[3]),
        .i_bit2    (dip[2]),
        .i_bit1    (dip[1]),
        .i_bit0    (dip[0]),
        .the_led   (the_led),
        .o_led0    (o_led0),
        .o_led1    (o_led1),
        .o_led2    (o_led2),
        .o_led3    (o_led3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic val;
    } led_ev_t;

    led_ev_t led_q[$];
    int      acc_q[$];
    int      compared   = 0;
    int      mismatched = 0;

    int         model_t   = 1;
    logic       model_led = 1'b0;
    logic       seg_valid = 1'b0;
    int         seg_start = 0;
    logic [7:0] seg_mask  = 8'h00;

    task automatic check_int(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic led_at(input int t);
        logic [2:0] idx;
        if (!seg_valid) return 1'b0;
        idx = 3'(7 - (((t - seg_start) / STEP) % 8));
        return seg_mask[idx];
    endfunction

    task automatic push_until(input int t_end);
        logic v;
        while (model_t < t_end) begin
            v = led_at(model_t);
            if (v != model_led) begin
                led_q.push_back('{model_t, v});
                model_led = v;
            end
            model_t++;
        end
    endtask

    task automatic advance_to(input int x);
        push_until(x + 1);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int len, input logic [7:0] sw, input bit exp_acc);
        int e;
        int a;
        dip        = sw;
        e          = cyc;
        the_button = 1'b0;
        if (exp_acc) begin
            a = e + LAT;
            acc_q.push_back(a);
            push_until(a + 2);
            seg_valid = 1'b1;
            seg_start = a + 2;
            seg_mask  = ~sw;
        end
        advance_to(e + len);
        the_button = 1'b1;
    endtask

    // LED monitor: every change of the_led must match the next queued event.
    logic    prev_led = 1'b0;
    led_ev_t ev;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (the_led !== prev_led) begin
                if (led_q.size() == 0) begin
                    check_int("led_unexpected_change", cyc, -1);
                end else begin
                    ev = led_q.pop_front();
                    check_int("led_change_cycle", cyc, ev.cyc);
                    check_bit("led_change_value", the_led, ev.val);
                end
                prev_led = the_led;
            end
            while (led_q.size() > 0 && led_q[0].cyc < cyc) begin
                ev = led_q.pop_front();
                check_int("led_change_missed", cyc, ev.cyc);
            end
        end
    end

    // Accept monitor.
    int exp_a;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (dut.accept === 1'b1) begin
                if (acc_q.size() == 0) begin
                    check_int("accept_unexpected", cyc, -1);
                end else begin
                    exp_a = acc_q.pop_front();
                    check_int("accept_cycle", cyc, exp_a);
                end
            end
            while (acc_q.size() > 0 && acc_q[0] < cyc) begin
                exp_a = acc_q.pop_front();
                check_int("accept_missed", cyc, exp_a);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        advance_to(1);
        check_bit("por_rst_c1", rst_o, 1'b1);
        check_bit("led3_c1", o_led3, 1'b1);
        check_bit("the_led_c1", the_led, 1'b0);
        check_bit("led0_c1", o_led0, 1'b0);
        check_bit("led1_c1", o_led1, 1'b0);
        check_bit("led2_c1", o_led2, 1'b0);
        advance_to(15);
        check_bit("por_rst_c15", rst_o, 1'b1);
        advance_to(16);
        check_bit("por_rst_c16", rst_o, 1'b0);
        check_bit("led3_c16", o_led3, 1'b0);
        check_bit("led0_c16", o_led0, 1'b0);
        check_bit("led2_c16", o_led2, 1'b0);

        // First press: mask 10100000, accept at cycle 38.
        advance_to(20);
        press(50, 8'b0101_1111, 1'b1);
        check_bit("run_after_first", o_led0, 1'b1);
        check_bit("pressed_held", o_led1, 1'b1);
        check_bit("lockout_after_first", o_led2, 1'b1);
        dip = 8'hA5;

        // Short glitch with different switches: nothing changes.
        advance_to(600);
        press(10, 8'h00, 1'b0);
        check_bit("glitch_not_pressed", o_led1, 1'b0);

        // Press 1000 cycles after accept lands in lockout.
        advance_to(1038);
        check_bit("lockout_before_press", o_led2, 1'b1);
        press(50, 8'b0011_0011, 1'b0);
        check_bit("lockout_after_press", o_led2, 1'b1);
        check_bit("lockout_press_debounced", o_led1, 1'b1);

        // New pattern 11001100 after lockout expired.
        advance_to(9000);
        check_bit("lockout_expired", o_led2, 1'b0);
        press(37, 8'b0011_0011, 1'b1);

        // Held press with all switches off: one accept, dark LED, run stays 1.
        advance_to(17500);
        press(20000, 8'hFF, 1'b1);
        check_bit("held_pressed", o_led1, 1'b1);
        check_bit("held_run", o_led0, 1'b1);
        check_bit("held_dark", the_led, 1'b0);

        // All switches on: steady LED.
        advance_to(38000);
        press(30, 8'h00, 1'b1);
        advance_to(40000);
        check_bit("steady_on", the_led, 1'b1);
        @(negedge clk);
        #1;
        check_int("led_events_left", led_q.size(), 0);
        check_int("accepts_left", acc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
